// File: rtl/jtag_master.sv
// JTAG master: resets the target TAP, then runs one IR scan + DR scan per command.
// Optional JTAG_MASTER_IR_SKIP_EN skips the IR scan when the instruction matches the last one loaded.
module jtag_master #(
  parameter int IR_WIDTH = 8,
  parameter int DR_WIDTH = 8,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);
  localparam int CW = 7;
  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
  localparam logic [CW-1:0] IR_LAST  = CW'(IR_WIDTH - 1);
  localparam logic [CW-1:0] DR_LAST  = CW'(DR_WIDTH - 1);
  localparam logic [CW-1:0] TLR_ONES = CW'(5);
  localparam logic [IR_WIDTH-1:0] IR_ONE = IR_WIDTH'(1);
  localparam logic [DR_WIDTH-1:0] DR_ONE = DR_WIDTH'(1);

  typedef enum logic [3:0] {
    TLR_SEQ, RTI, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR,
    CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] dr_q, dr_d, cap_q, cap_d, rsp_q, rsp_d;
  logic                rsp_vld_q, rsp_vld_d, rdy_q, rdy_d, busy_q, busy_d;
  logic                irdone_q, irdone_d, done_q, done_d, cdone_q, cdone_d;
`ifdef JTAG_MASTER_IR_SKIP_EN
  logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
  logic                last_vld_q, last_vld_d;
`endif

  logic accept, start, running, tc, rise, fall, ir_bit, dr_bit;

  assign accept  = cmd_valid && rdy_q;
  assign start   = accept || busy_q;
  // The divider parks with tck low while idle in Run-Test/Idle.
  assign running = tck_q || (state_q != RTI) || busy_q;
  assign tc      = (div_q == DIV_LAST);
  assign rise    = running && tc && !tck_q;
  assign fall    = running && tc && tck_q;
  assign ir_bit  = |(ir_q & (IR_ONE << cnt_q));
  assign dr_bit  = |(dr_q & (DR_ONE << cnt_q));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    ir_d      = ir_q;
    dr_d      = dr_q;
    cap_d     = cap_q;
    rsp_d     = rsp_q;
    rsp_vld_d = 1'b0;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    irdone_d  = irdone_q;
    done_d    = 1'b0;
    cdone_d   = 1'b0;
`ifdef JTAG_MASTER_IR_SKIP_EN
    last_ir_d  = last_ir_q;
    last_vld_d = last_vld_q;
`endif

    if (running) div_d = tc ? '0 : div_q + DW'(1);
    if (rise || fall) tck_d = ~tck_q;

    if (accept) begin
      rdy_d  = 1'b0;
      busy_d = 1'b1;
      ir_d   = cmd_ir;
      dr_d   = cmd_dr;
`ifdef JTAG_MASTER_IR_SKIP_EN
      irdone_d = last_vld_q && (cmd_ir == last_ir_q);
`else
      irdone_d = 1'b0;
`endif
      // Idle with tck parked low: present tms=1 now so the first rise leaves RTI.
      if (!tck_q) tms_d = 1'b1;
    end

    // Falling edge: drive tms/tdi for the upcoming TCK cycle.
    if (fall) begin
      tdi_d = 1'b0;
      unique case (state_q)
        TLR_SEQ:  tms_d = (cnt_q < TLR_ONES);
        RTI:      tms_d = start;
        SEL_DR:   tms_d = !irdone_q;
        SHIFT_IR: begin tms_d = (cnt_q == IR_LAST); tdi_d = ir_bit; end
        SHIFT_DR: begin tms_d = (cnt_q == DR_LAST); tdi_d = dr_bit; end
        EXIT1_IR, UPD_IR, EXIT1_DR: tms_d = 1'b1;
        default:  tms_d = 1'b0;
      endcase
    end

    // Rising edge: follow the target TAP and sample tdo.
    if (rise) begin
      unique case (state_q)
        TLR_SEQ: begin
          cnt_d = cnt_q + CW'(1);
          if (!tms_q) begin state_d = RTI; cnt_d = '0; done_d = 1'b1; end
        end
        RTI:      if (tms_q) state_d = SEL_DR;
        SEL_DR:   state_d = tms_q ? SEL_IR : CAP_DR;
        SEL_IR:   state_d = CAP_IR;
        CAP_IR:   begin state_d = SHIFT_IR; cnt_d = '0; end
        SHIFT_IR: begin
          cnt_d = cnt_q + CW'(1);
          if (tms_q) begin state_d = EXIT1_IR; cnt_d = '0; end
        end
        EXIT1_IR: state_d = UPD_IR;
        UPD_IR: begin
          state_d  = SEL_DR;
          irdone_d = 1'b1;
`ifdef JTAG_MASTER_IR_SKIP_EN
          last_ir_d  = ir_q;
          last_vld_d = 1'b1;
`endif
        end
        CAP_DR:   begin state_d = SHIFT_DR; cnt_d = '0; end
        SHIFT_DR: begin
          cap_d = DR_WIDTH'({tdo, cap_q} >> 1);
          cnt_d = cnt_q + CW'(1);
          if (tms_q) begin state_d = EXIT1_DR; cnt_d = '0; end
        end
        EXIT1_DR: state_d = UPD_DR;
        UPD_DR: begin
          state_d = RTI;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cdone_d = 1'b1;
        end
        default:  state_d = TLR_SEQ;
      endcase
    end

    if (done_q) begin
      rdy_d = 1'b1;
      if (cdone_q) begin rsp_vld_d = 1'b1; rsp_d = cap_q; end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TLR_SEQ;
      div_q     <= '0;
      cnt_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      ir_q      <= '0;
      dr_q      <= '0;
      cap_q     <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      irdone_q  <= 1'b0;
      done_q    <= 1'b0;
      cdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      ir_q      <= ir_d;
      dr_q      <= dr_d;
      cap_q     <= cap_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      irdone_q  <= irdone_d;
      done_q    <= done_d;
      cdone_q   <= cdone_d;
    end
  end

`ifdef JTAG_MASTER_IR_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ir_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_ir_q  <= last_ir_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

  assign cmd_ready = rdy_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_dr    = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter IR_WIDTH, default 8, instruction register length in bits (2..32).
REQ-002 Parameter DR_WIDTH, default 8, data register length in bits (1..64).
REQ-003 Parameter TCK_DIV, default 2, clk cycles per TCK half-period (>=1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  master idle in Run-Test/Idle; command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_ir  input  IR_WIDTH  instruction to load.
REQ-009 cmd_dr  input  DR_WIDTH  data to shift in.
REQ-010 rsp_valid  output  1  one-cycle pulse; rsp_dr is valid.
REQ-011 rsp_dr  output  DR_WIDTH  TDO bits captured during Shift-DR.
REQ-012 tck, tms, tdi  output  1 each  JTAG drive to target TAP.
REQ-013 tdo  input  1  JTAG return from target TAP.

Function
REQ-014 TCK period = 2*TCK_DIV clk cycles; tck changes only on clk edges.
REQ-015 tms/tdi update on the clk edge where tck falls; tdo sampled on the clk edge where tck rises.
REQ-016 States: TLR_SEQ, RTI, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR, CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR; they mirror the target TAP state.
REQ-017 TLR_SEQ: 5 TCK cycles with tms=1, then 1 TCK cycle with tms=0 -> RTI.
REQ-018 Command sequence from RTI, tms per TCK: 1,1,0,0 (Shift-IR); IR_WIDTH shift cycles, tms=1 on the last only; 1 (Update-IR), 1 (Select-DR), 0, 0 (Shift-DR); DR_WIDTH shift cycles, tms=1 on the last only; 1 (Update-DR), 0 (RTI).
REQ-019 Full command = IR_WIDTH+DR_WIDTH+10 TCK cycles.
REQ-020 Shift order LSB first, for both tdi and tdo; rsp_dr[i] = tdo sampled on the i-th Shift-DR rising edge.
REQ-021 tdi = 0 outside Shift-IR/Shift-DR.
REQ-022 cmd_ir/cmd_dr are registered on acceptance; later input changes are ignored.
REQ-023 cmd_ready deasserts the cycle after acceptance and reasserts with rsp_valid.
REQ-024 rsp_valid pulses for 1 clk, 1 cycle after the tck rising edge entering RTI.
REQ-025 rsp_dr holds its value until the next rsp_valid.
REQ-026 There is no response backpressure.
REQ-027 cmd_valid arriving while cmd_ready=0 is not accepted; it is held by the requester until ready.
REQ-028 tck idles low in RTI with tms=0.

Reset
REQ-029 Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_dr=0, state=TLR_SEQ.
REQ-030 Reset mid-command aborts immediately, with no rsp_valid.
REQ-031 On release of rst_n, TLR_SEQ runs, then cmd_ready=1 in RTI.

Configuration
REQ-032 Macro JTAG_MASTER_IR_SKIP_EN.
REQ-033 When JTAG_MASTER_IR_SKIP_EN is defined: the last loaded IR is stored, with a valid flag cleared by reset.
REQ-034 When JTAG_MASTER_IR_SKIP_EN is defined and cmd_ir equals the stored IR: RTI -> SEL_DR -> CAP_DR, skipping the IR scan; the command then takes DR_WIDTH+5 TCK cycles.
REQ-035 When JTAG_MASTER_IR_SKIP_EN is not defined, every command performs the IR scan.

Verification
REQ-036 Reset release, TCK_DIV=2 -> 6 TCK cycles, tms sequence 1,1,1,1,1,0; cmd_ready=1 at clk cycle 24.
REQ-037 cmd_ir=0x10, cmd_dr=0xA5, target model looping DR (tdo = tdi delayed one shift) -> tdi IR bits 0,0,0,0,1,0,0,0; 26 TCK cycles; rsp_valid once; rsp_dr per the target model.
REQ-038 Target returns DR capture 0x3C -> rsp_dr=0x3C; tms=1 only on the 8th Shift-DR cycle.
REQ-039 Two back-to-back commands, both with cmd_ir=0x10 -> 2nd takes 26 TCK cycles without JTAG_MASTER_IR_SKIP_EN, 13 with it; a 3rd command with cmd_ir=0x11 takes 26 in both builds.
REQ-040 rst_n asserted during Shift-DR -> tck=0 and tms=1 at once, no rsp_valid, TLR_SEQ restarts on release.
REQ-041 cmd_valid held with cmd_ir/cmd_dr changing after acceptance -> the registered values are the ones shifted; cmd_ready=0 throughout the command.
